icmp_echo_buffer: RTL and testbench

- Parametrised single-packet store-and-forward buffer for ICMP echo replies in the eth path.
- Captures a request (header word 0 plus payload) from the receive parser and computes the Internet checksum incrementally.
- Streams the reply to the transmit framer over valid/ready, with header word 0 rewritten to {REPLY_TC, checksum}.
- Generalises the ping payload store in width and depth, and adds back-pressure, overflow drop and restart handling.

---
 rtl/eth_pkg.sv | 12 +
 rtl/icmp_csum_acc.sv | 23 ++
 rtl/icmp_echo_buffer.sv | 110 +++++++++++
 tb/tb_icmp_echo_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM state encoding, ICMP type/code constants and the ones-complement fold.
package eth_pkg;
    typedef enum logic [1:0] {IDLE, FILL, CSUM, SEND} state_t;
    localparam logic [15:0] ECHO_REQ_TC   = 16'h0800;
    localparam logic [15:0] ECHO_REPLY_TC = 16'h0000;
    // Two end-around-carry folds of a 32-bit sum down to 16 bits.
    function automatic logic [15:0] ones_fold(input logic [31:0] x);
        logic [16:0] s;
        s = {1'b0, x[31:16]} + {1'b0, x[15:0]};
        return s[15:0] + {15'b0, s[16]};
    endfunction
endpackage

// File: rtl/icmp_csum_acc.sv
// icmp_csum_acc: 32-bit Internet-checksum accumulator over the 16-bit halves of each written word.
module icmp_csum_acc import eth_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [15:0]       init,
    input  logic [DATA_W-1:0] data,
    output logic [15:0]       sum
);
    logic [31:0] acc, halves;
    always_comb begin
        halves = '0;
        for (int i = 0; i < DATA_W / 16; i++) halves = halves + {16'b0, data[16*i +: 16]};
    end
    // clr reloads from init; clr together with en also folds in the current word.
    always_ff @(posedge clk)
        if (rst) acc <= '0;
        else if (clr | en) acc <= (clr ? {16'b0, init} : acc) + (en ? halves : 32'd0);
    assign sum = ones_fold(acc);
endmodule

// File: rtl/icmp_echo_buffer.sv
// icmp_echo_buffer: single-packet store-and-forward buffer turning an ICMP echo request into its reply.
// Define ICMP_RX_CSUM_CHECK_EN to verify the request checksum and drop packets that fail it.
module icmp_echo_buffer import eth_pkg::*; #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter logic [15:0] REPLY_TC = ECHO_REPLY_TC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_eop,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_rdy,
    output logic              o_out_valid,
    input  logic              i_out_rdy,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic [ADDR_W:0]   o_payload_size,
    output logic              o_ovf,
    output logic              o_csum_err
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] hdr;
    logic [ADDR_W:0]   wr_ptr, len;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       csum, tx_sum;
    logic              wr, first, bad;
    assign o_in_rdy = (state == IDLE) | (state == FILL);
    assign wr       = i_wren & o_in_rdy;
    assign first    = wr & i_start;
    // Reply checksum starts from the reply type/code; the request's word 0 never enters it.
    icmp_csum_acc #(.DATA_W(DATA_W)) u_tx_acc (
        .clk, .rst, .clr(first), .en(wr & ~i_start & (state == FILL)),
        .init(REPLY_TC), .data(i_in_data), .sum(tx_sum)
    );
`ifdef ICMP_RX_CSUM_CHECK_EN
    logic [15:0] rx_sum;
    icmp_csum_acc #(.DATA_W(DATA_W)) u_rx_acc (
        .clk, .rst, .clr(first), .en(first | (wr & (state == FILL))),
        .init(16'h0000), .data(i_in_data), .sum(rx_sum)
    );
    assign bad = rx_sum != 16'hFFFF;
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk)
        if (first | (wr & (state == FILL) & (wr_ptr != FULL)))
            mem[i_start ? '0 : wr_ptr[ADDR_W-1:0]] <= i_in_data;
    always_comb begin
        hdr = '0;
        hdr[DATA_W-1 -: 16] = REPLY_TC;
        hdr[15:0] = csum;
    end
    assign o_out_data = rd_ptr == '0 ? hdr : mem[rd_ptr];
    assign o_out_last = o_out_valid & ({1'b0, rd_ptr} == len - 1'b1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len            <= '0;
            csum           <= '0;
            o_out_valid    <= 1'b0;
            o_payload_size <= '0;
            o_ovf          <= 1'b0;
            o_csum_err     <= 1'b0;
        end else begin
            o_ovf      <= 1'b0;
            o_csum_err <= 1'b0;
            case (state)
                IDLE, FILL: if (first) begin
                    wr_ptr <= (ADDR_W + 1)'(1);
                    len    <= (ADDR_W + 1)'(1);
                    state  <= i_eop ? CSUM : FILL;
                end else if (wr & (state == FILL)) begin
                    if (wr_ptr == FULL) begin
                        o_ovf  <= 1'b1;
                        wr_ptr <= '0;
                        state  <= IDLE;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (i_eop) begin
                            len   <= wr_ptr + 1'b1;
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    csum        <= ~tx_sum;
                    rd_ptr      <= '0;
                    o_csum_err  <= bad;
                    o_out_valid <= ~bad;
                    if (!bad) o_payload_size <= len;
                    state       <= bad ? IDLE : SEND;
                end
                SEND: if (i_out_rdy) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (o_out_last) begin
                        o_out_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icmp_echo_buffer.sv
// tb_icmp_echo_buffer: randomized self-checking bench for icmp_echo_buffer against a ones-complement reply model.
module tb_icmp_echo_buffer;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RTC   = 16'h0000;
    logic        clk = 0, rst = 1, i_start = 0, i_eop = 0, i_wren = 0, i_out_rdy = 0;
    logic [31:0] i_in_data = 0;
    logic        o_in_rdy, o_out_valid, o_out_last, o_ovf, o_csum_err;
    logic [31:0] o_out_data;
    logic [2:0]  o_payload_size;
    int          tests = 0, fails = 0;
    logic [31:0] req[$];
    logic [31:0] got[$];
    bit          got_last[$];
    int          first_cyc, viol, errs, ovfs;
    bit          done;

    icmp_echo_buffer #(.DATA_W(32), .DEPTH(DEPTH), .REPLY_TC(RTC)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_eop(i_eop), .i_wren(i_wren),
        .i_in_data(i_in_data), .o_in_rdy(o_in_rdy), .o_out_valid(o_out_valid),
        .i_out_rdy(i_out_rdy), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .o_payload_size(o_payload_size), .o_ovf(o_ovf), .o_csum_err(o_csum_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] osum(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + 16'(s[16]);
    endfunction

    function automatic logic [15:0] reply_csum();
        logic [15:0] s;
        s = RTC;
        for (int i = 1; i < req.size(); i++) s = osum(osum(s, req[i][31:16]), req[i][15:0]);
        return ~s;
    endfunction

    function automatic bit rx_bad();
`ifdef ICMP_RX_CSUM_CHECK_EN
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < req.size(); i++) s = osum(osum(s, req[i][31:16]), req[i][15:0]);
        return s != 16'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_beat(input int i);
        return i == 0 ? {RTC, reply_csum()} : req[i];
    endfunction

    // Builds an n-word echo request whose word 0 carries a correct checksum, optionally corrupted.
    task automatic make_req(input int n, input bit corrupt);
        logic [15:0] s;
        logic [31:0] w;
        s = 16'h0800;
        req = {32'h0};
        for (int i = 1; i < n; i++) begin
            w = $urandom;
            req.push_back(w);
            s = osum(osum(s, w[31:16]), w[15:0]);
        end
        req[0] = {16'h0800, ~s};
        if (corrupt) req[n-1] = req[n-1] ^ 32'h1;
    endtask

    task automatic put(input logic [31:0] d, input bit s, input bit e);
        @(negedge clk);
        i_wren = 1; i_start = s; i_eop = e; i_in_data = d;
    endtask

    task automatic send_req();
        for (int i = 0; i < req.size(); i++) put(req[i], i == 0, i == req.size() - 1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1 per valid cycle, 2: random ready.
    task automatic collect(input int mode, input bit junk, input int budget);
        logic [31:0] held;
        bit stalled, r;
        int k;
        held = 0; stalled = 0; k = 0;
        got = {}; got_last = {}; first_cyc = 0; viol = 0; errs = 0; ovfs = 0; done = 0;
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            if (stalled && (o_out_valid !== 1'b1 || o_out_data !== held)) viol++;
            if (o_out_valid === 1'b1 && o_in_rdy !== 1'b0) viol++;
            if (o_csum_err === 1'b1) errs++;
            if (o_ovf === 1'b1) ovfs++;
            i_wren = junk; i_start = junk; i_eop = junk; i_in_data = $urandom;
            r = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 1 || k % 4 == 2 ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1));
            i_out_rdy = r;
            stalled = 0;
            if (o_out_valid === 1'b1) begin
                if (first_cyc == 0) first_cyc = c;
                k++;
                if (r) begin
                    got.push_back(o_out_data);
                    got_last.push_back(o_out_last);
                    done = o_out_last;
                end else begin
                    held = o_out_data;
                    stalled = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) begin @(negedge clk); i_wren = 0; i_start = 0; i_eop = 0; end
        tests++; if ({o_out_valid, o_out_last, o_ovf, o_csum_err} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {o_out_valid, o_out_last, o_ovf, o_csum_err}); end
        tests++; if (o_in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy: got %b expected 1", o_in_rdy); end
        tests++; if (o_payload_size !== 3'd0) begin fails++; $display("FAIL reset_size: got %0d expected 0", o_payload_size); end
        rst = 0;
    endtask

    task automatic test_basic();
        put(32'h0800F7FC, 1, 0);
        put(32'h00010002, 0, 1);
        collect(0, 0, 10);
        tests++; if (got.size() != 2) begin fails++; $display("FAIL basic_beats: got %0d expected 2", got.size()); end
        else begin
            tests++; if (got[0] !== 32'h0000FFFC) begin fails++; $display("FAIL basic_w0: got %h expected 0000fffc", got[0]); end
            tests++; if (got[1] !== 32'h00010002) begin fails++; $display("FAIL basic_w1: got %h expected 00010002", got[1]); end
            tests++; if ({got_last[0], got_last[1]} !== 2'b01) begin fails++; $display("FAIL basic_last: got %b expected 01", {got_last[0], got_last[1]}); end
        end
        tests++; if (first_cyc != 2) begin fails++; $display("FAIL basic_latency: got %0d expected 2", first_cyc); end
        tests++; if (o_payload_size !== 3'd2) begin fails++; $display("FAIL basic_size: got %0d expected 2", o_payload_size); end
        tests++; if (errs != 0) begin fails++; $display("FAIL basic_csum_err: got %0d expected 0", errs); end
    endtask

    task automatic test_carry();
        put(32'h0800F7FD, 1, 0);
        put(32'hFFFFFFFF, 0, 0);
        put(32'h00000002, 0, 1);
        collect(0, 0, 12);
        tests++; if (got.size() != 3) begin fails++; $display("FAIL carry_beats: got %0d expected 3", got.size()); end
        else begin
            tests++; if (got[0] !== 32'h0000FFFD) begin fails++; $display("FAIL carry_w0: got %h expected 0000fffd", got[0]); end
            tests++; if (got[1] !== 32'hFFFFFFFF || got[2] !== 32'h00000002) begin fails++; $display("FAIL carry_payload: got %h %h expected ffffffff 00000002", got[1], got[2]); end
        end
    endtask

    task automatic test_overflow();
        int pulses, at, bad_rdy, bad_vld;
        pulses = 0; at = 0; bad_rdy = 0; bad_vld = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_ovf === 1'b1) begin pulses++; at = i; end
            if (o_in_rdy !== 1'b1) bad_rdy++;
            if (o_out_valid !== 1'b0) bad_vld++;
            i_wren = i < 5; i_start = i == 0; i_eop = 0; i_in_data = $urandom;
        end
        tests++; if (pulses != 1 || at != 5) begin fails++; $display("FAIL ovf_pulse: got %0d pulses at cycle %0d expected 1 at cycle 5", pulses, at); end
        tests++; if (bad_rdy != 0) begin fails++; $display("FAIL ovf_in_rdy: got %0d low cycles expected 0", bad_rdy); end
        tests++; if (bad_vld != 0) begin fails++; $display("FAIL ovf_valid: got %0d valid cycles expected 0", bad_vld); end
        make_req(DEPTH, 0);
        send_req();
        collect(0, 0, 20);
        tests++; if (got.size() != DEPTH || ovfs != 0) begin fails++; $display("FAIL full_depth: got %0d beats %0d ovf expected %0d beats 0 ovf", got.size(), ovfs, DEPTH); end
        else for (int i = 0; i < DEPTH; i++) begin
            tests++; if (got[i] !== exp_beat(i)) begin fails++; $display("FAIL full_depth_w%0d: got %h expected %h", i, got[i], exp_beat(i)); end
        end
    endtask

    task automatic test_backpressure();
        make_req(4, 0);
        send_req();
        collect(1, 1, 30);
        tests++; if (got.size() != 4) begin fails++; $display("FAIL bp_beats: got %0d expected 4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            tests++; if (got[i] !== exp_beat(i) || got_last[i] !== (i == 3)) begin fails++; $display("FAIL bp_w%0d: got %h last %b expected %h last %b", i, got[i], got_last[i], exp_beat(i), i == 3); end
        end
        tests++; if (viol != 0) begin fails++; $display("FAIL bp_stable: got %0d violations expected 0", viol); end
        @(negedge clk);
        i_wren = 0; i_start = 0; i_eop = 0;
        tests++; if (o_out_valid !== 1'b0) begin fails++; $display("FAIL bp_after: got valid %b expected 0", o_out_valid); end
    endtask

    task automatic test_restart();
        put($urandom, 1, 0);
        put($urandom, 0, 0);
        put($urandom, 0, 0);
        make_req(3, 0);
        send_req();
        collect(0, 0, 20);
        tests++; if (got.size() != 3) begin fails++; $display("FAIL restart_beats: got %0d expected 3", got.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests++; if (got[i] !== exp_beat(i)) begin fails++; $display("FAIL restart_w%0d: got %h expected %h", i, got[i], exp_beat(i)); end
        end
        @(negedge clk);
        tests++; if (o_out_valid !== 1'b0) begin fails++; $display("FAIL restart_extra: got valid %b expected 0", o_out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen, spurious;
        make_req(4, 0);
        send_req();
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            @(negedge clk);
            i_wren = 0; i_start = 0; i_eop = 0; i_out_rdy = 0;
            if (o_out_valid === 1'b1) seen = 1;
        end
        tests++; if (seen != 1) begin fails++; $display("FAIL rst_send_wait: got no valid expected valid within 6 cycles"); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        i_out_rdy = 1;
        tests++; if (o_out_valid !== 1'b0 || o_in_rdy !== 1'b1) begin fails++; $display("FAIL rst_send_state: got valid %b in_rdy %b expected 0 1", o_out_valid, o_in_rdy); end
        tests++; if (o_payload_size !== 3'd0) begin fails++; $display("FAIL rst_send_size: got %0d expected 0", o_payload_size); end
        put($urandom, 1, 0);
        put($urandom, 0, 0);
        @(negedge clk);
        rst = 1; i_wren = 0;
        @(negedge clk);
        rst = 0;
        put($urandom, 0, 1);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_wren = 0; i_start = 0; i_eop = 0;
            if (o_out_valid !== 1'b0) spurious++;
        end
        tests++; if (spurious != 0) begin fails++; $display("FAIL rst_fill_drop: got %0d valid cycles expected 0", spurious); end
    endtask

    task automatic test_csum_check();
        put(32'h0800F7FC, 1, 0);
        put(32'h00010003, 0, 1);
        collect(0, 0, 8);
`ifdef ICMP_RX_CSUM_CHECK_EN
        tests++; if (errs != 1) begin fails++; $display("FAIL csum_err_pulse: got %0d expected 1", errs); end
        tests++; if (got.size() != 0 || first_cyc != 0) begin fails++; $display("FAIL csum_err_drop: got %0d beats expected 0", got.size()); end
`else
        tests++; if (errs != 0) begin fails++; $display("FAIL csum_err_tied: got %0d expected 0", errs); end
        tests++; if (got.size() != 2 || got[0] !== 32'h0000FFFB) begin fails++; $display("FAIL csum_nocheck: got %0d beats w0 %h expected 2 beats 0000fffb", got.size(), got.size() > 0 ? got[0] : 32'h0); end
`endif
    endtask

    task automatic test_random();
        bit drop, junk;
        int n, mode;
        for (int k = 0; k < 24; k++) begin
            n = k % DEPTH + 1;
            mode = k % 3;
            make_req(n, $urandom_range(0, 3) == 0);
            drop = rx_bad();
            junk = !drop && $urandom_range(0, 1) == 1;
            send_req();
            collect(mode, junk, drop ? 8 : 40);
            if (drop) begin
                tests++; if (got.size() != 0 || errs != 1) begin fails++; $display("FAIL rnd%0d_drop: got %0d beats %0d errs expected 0 beats 1 err", k, got.size(), errs); end
            end else begin
                tests++; if (got.size() != n || errs != 0 || viol != 0) begin fails++; $display("FAIL rnd%0d_len: got %0d beats %0d errs %0d viol expected %0d 0 0", k, got.size(), errs, viol, n); end
                else for (int i = 0; i < n; i++) begin
                    tests++; if (got[i] !== exp_beat(i) || got_last[i] !== (i == n - 1)) begin fails++; $display("FAIL rnd%0d_w%0d: got %h last %b expected %h last %b", k, i, got[i], got_last[i], exp_beat(i), i == n - 1); end
                end
                tests++; if (o_payload_size !== 3'(n)) begin fails++; $display("FAIL rnd%0d_size: got %0d expected %0d", k, o_payload_size, n); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_backpressure();
        test_restart();
        test_reset_mid();
        test_csum_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
